// File: rtl/apb_global_pkg.sv
// Shared APB widths, completer FSM state encoding and the latched request record.
package apb_global_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int STRB_WIDTH    = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_slave_state_e;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     write;
    logic [STRB_WIDTH-1:0]    strb;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [2:0]               prot;
  } apb_req_t;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between one interconnect slave port and the memory completer.
interface apb_slave_mem_if;
  import apb_global_pkg::*;

  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic                     pwrite;
  logic [STRB_WIDTH-1:0]    pstrb;
  logic [DATA_WIDTH-1:0]    pwdata;
  logic [2:0]               pprot;
  logic [DATA_WIDTH-1:0]    prdata;
  logic                     pready;
  logic                     pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pstrb, pwdata, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pstrb, pwdata, pprot,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_wait_gen.sv
// Loadable down-counter for ACCESS wait states; zero_o flags that pready may rise.
// Load takes priority over decrement; the count saturates at zero.
module apb_wait_gen #(
  parameter int CNT_W = 4
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a zero-reset word memory; completes WAIT_STATES+2 cycles after psel.
// Define APB_SLAVE_PROT_CHECK_EN to reject non-secure accesses to the upper half of memory.
module apb_slave_mem
  import apb_global_pkg::*;
#(
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                       MEM_WORDS_LOG2 = 8,
  parameter int                       WAIT_STATES    = 0
) (
  input logic            pclk,
  input logic            preset_n,
  apb_slave_mem_if.slave apb
);

  localparam int         MEM_WORDS = 1 << MEM_WORDS_LOG2;
  localparam int         ADDR_LSB  = $clog2(STRB_WIDTH);
  localparam int         IDX_HI    = MEM_WORDS_LOG2 + ADDR_LSB;
  localparam logic [3:0] WAIT_LD   = 4'(WAIT_STATES);

  apb_slave_state_e         state_q, state_d;
  apb_req_t                 req_q, req_d;
  logic [DATA_WIDTH-1:0]    mem_q [MEM_WORDS];
  logic                     latch_en;
  logic                     in_access;
  logic                     cnt_zero;
  logic                     completion;
  logic                     out_of_range;
  logic                     prot_err;
  logic                     access_err;
  logic                     do_write;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [MEM_WORDS_LOG2-1:0] word_idx;
  logic                     unused_bits;

  apb_wait_gen #(.CNT_W(4)) u_wait_gen (
    .pclk       (pclk),
    .preset_n   (preset_n),
    .load_i     (latch_en),
    .load_val_i (WAIT_LD),
    .dec_i      (in_access),
    .zero_o     (cnt_zero)
  );

  assign in_access  = (state_q == ACCESS);
  assign apb.pready = in_access & cnt_zero;
  assign completion = apb.pready & apb.psel & apb.penable;

  // penable seen in IDLE without a setup phase is ignored; a dropped psel aborts.
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) state_d = SETUP;
      end
      SETUP: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else begin
          state_d  = ACCESS;
          latch_en = 1'b1;
        end
      end
      ACCESS: begin
        if (!apb.psel || completion) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;
    if (latch_en) begin
      req_d = '{addr:  apb.paddr,  write: apb.pwrite, strb: apb.pstrb,
                wdata: apb.pwdata, prot:  apb.pprot};
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // Wrapping subtraction folds addresses below BASE_ADDR into the out-of-range set.
  assign offset       = req_q.addr - BASE_ADDR;
  assign word_idx     = offset[IDX_HI-1:ADDR_LSB];
  assign out_of_range = |offset[ADDRESS_WIDTH-1:IDX_HI];

`ifdef APB_SLAVE_PROT_CHECK_EN
  assign prot_err    = req_q.prot[1] & word_idx[MEM_WORDS_LOG2-1];
  assign unused_bits = ^{req_q.prot[2], req_q.prot[0], offset[ADDR_LSB-1:0]};
`else
  assign prot_err    = 1'b0;
  assign unused_bits = ^{req_q.prot, offset[ADDR_LSB-1:0]};
`endif

  assign access_err  = out_of_range | prot_err;
  assign do_write    = completion & req_q.write & ~access_err;
  assign apb.pslverr = completion & access_err;
  assign apb.prdata  = (completion && !req_q.write && !access_err) ? mem_q[word_idx] : '0;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (req_q.strb[b]) mem_q[word_idx][b*8 +: 8] <= req_q.wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed vector table plus hand sequences for abort, stray penable and mid-access reset.
module tb_apb_slave_mem;

`ifdef APB_SLAVE_PROT_CHECK_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  localparam int LAT = 4;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [2:0]  prot;
    logic        b2b;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic pclk;
  logic preset_n;
  int   checks;
  int   errors;
  vec_t vq[$];

  apb_slave_mem_if bus();

  apb_slave_mem #(
    .BASE_ADDR      (32'h0000_1000),
    .MEM_WORDS_LOG2 (8),
    .WAIT_STATES    (2)
  ) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .apb      (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string name, logic [31:0] addr, logic wr, logic [3:0] strb,
                              logic [31:0] wdata, logic [2:0] prot, logic b2b,
                              logic [31:0] exp_rdata, logic exp_err);
    vec_t v;
    v.name = name; v.addr = addr; v.wr = wr; v.strb = strb; v.wdata = wdata;
    v.prot = prot; v.b2b = b2b; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic go_idle();
    @(posedge pclk); #1;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
  endtask

  // Returns at the negedge of the cycle where pready is first seen high (or after the bound).
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [3:0] strb,
                          input logic [31:0] wdata, input logic [2:0] prot,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic wait_bad);
    bit done;
    lat = 0; done = 1'b0; wait_bad = 1'b0;
    @(posedge pclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = addr; bus.pwrite = wr;
    bus.pstrb = strb; bus.pwdata = wdata; bus.pprot = prot;
    while (!done && lat < 40) begin
      @(posedge pclk); #1;
      bus.penable = 1'b1;
      lat++;
      @(negedge pclk);
      if (bus.pready) done = 1'b1;
      else if (bus.prdata != 32'h0 || bus.pslverr) wait_bad = 1'b1;
    end
    rdata = bus.prdata;
    err = bus.pslverr;
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        wbad;
    logic        stray;

    checks = 0; errors = 0;
    preset_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0; bus.pwrite = 1'b0;
    bus.pstrb = '0; bus.pwdata = '0; bus.pprot = '0;

    vq.push_back(mk("wr_deadbeef",  32'h1004, 1, 4'hF, 32'hDEAD_BEEF, 3'b000, 0, 32'h0,         0));
    vq.push_back(mk("rd_deadbeef",  32'h1004, 0, 4'hF, 32'h0,         3'b000, 0, 32'hDEAD_BEEF, 0));
    vq.push_back(mk("wr_ones",      32'h1008, 1, 4'hF, 32'hFFFF_FFFF, 3'b000, 0, 32'h0,         0));
    vq.push_back(mk("wr_strb5",     32'h1008, 1, 4'h5, 32'h1122_3344, 3'b000, 0, 32'h0,         0));
    vq.push_back(mk("rd_strb5",     32'h1008, 0, 4'hF, 32'h0,         3'b000, 0, 32'hFF22_FF44, 0));
    vq.push_back(mk("rd_below",     32'h0FFC, 0, 4'hF, 32'h0,         3'b000, 0, 32'h0,         1));
    vq.push_back(mk("rd_above",     32'h1400, 0, 4'hF, 32'h0,         3'b000, 0, 32'h0,         1));
    vq.push_back(mk("wr_above",     32'h1400, 1, 4'hF, 32'hAAAA_5555, 3'b000, 0, 32'h0,         1));
    vq.push_back(mk("wr_below",     32'h0FFC, 1, 4'hF, 32'h5555_AAAA, 3'b000, 0, 32'h0,         1));
    vq.push_back(mk("rd_word0",     32'h1000, 0, 4'hF, 32'h0,         3'b000, 0, 32'h0,         0));
    vq.push_back(mk("rd_lastword",  32'h13FC, 0, 4'hF, 32'h0,         3'b000, 0, 32'h0,         0));
    vq.push_back(mk("rd_strb5_again", 32'h1008, 0, 4'hF, 32'h0,       3'b000, 0, 32'hFF22_FF44, 0));
    vq.push_back(mk("wr_lastword",  32'h13FC, 1, 4'hF, 32'h1234_5678, 3'b000, 0, 32'h0,         0));
    vq.push_back(mk("rd_lastword2", 32'h13FC, 0, 4'hF, 32'h0,         3'b000, 0, 32'h1234_5678, 0));
    vq.push_back(mk("wr_strb0",     32'h100C, 1, 4'h0, 32'hCAFE_F00D, 3'b000, 0, 32'h0,         0));
    vq.push_back(mk("rd_strb0",     32'h100C, 0, 4'hF, 32'h0,         3'b000, 0, 32'h0,         0));
    vq.push_back(mk("wr_b2b",       32'h1000, 1, 4'hF, 32'h0BAD_F00D, 3'b000, 0, 32'h0,         0));
    vq.push_back(mk("rd_b2b",       32'h1000, 0, 4'hF, 32'h0,         3'b000, 1, 32'h0BAD_F00D, 0));
    vq.push_back(mk("wr_b2b2",      32'h1014, 1, 4'hF, 32'h5A5A_A5A5, 3'b000, 1, 32'h0,         0));
    vq.push_back(mk("rd_b2b2",      32'h1014, 0, 4'hF, 32'h0,         3'b000, 1, 32'h5A5A_A5A5, 0));
    vq.push_back(mk("wr_prot_ns",   32'h1200, 1, 4'hF, 32'h0000_0077, 3'b010, 0, 32'h0,         PROT));
    vq.push_back(mk("rd_prot_s",    32'h1200, 0, 4'hF, 32'h0,         3'b000, 0,
                    PROT ? 32'h0 : 32'h0000_0077, 0));
    vq.push_back(mk("rd_prot_ns",   32'h1200, 0, 4'hF, 32'h0,         3'b010, 0,
                    PROT ? 32'h0 : 32'h0000_0077, PROT));
    vq.push_back(mk("wr_prot_s",    32'h1200, 1, 4'hF, 32'h0000_0099, 3'b000, 0, 32'h0,         0));
    vq.push_back(mk("rd_prot_s2",   32'h1200, 0, 4'hF, 32'h0,         3'b000, 0, 32'h0000_0099, 0));
    vq.push_back(mk("rd_lower_ns",  32'h1004, 0, 4'hF, 32'h0,         3'b010, 0, 32'hDEAD_BEEF, 0));

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    check("reset_pready", {31'h0, bus.pready}, 32'h0);
    check("reset_pslverr", {31'h0, bus.pslverr}, 32'h0);
    check("reset_prdata", bus.prdata, 32'h0);

    // Stray access phase with no setup must not be accepted.
    stray = 1'b0;
    @(posedge pclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b1; bus.paddr = 32'h1004; bus.pwrite = 1'b0;
    repeat (5) begin
      @(negedge pclk);
      if (bus.pready) stray = 1'b1;
    end
    check("stray_penable_pready", {31'h0, stray}, 32'h0);
    go_idle();

    foreach (vq[i]) begin
      if (!vq[i].b2b) go_idle();
      apb_xfer(vq[i].addr, vq[i].wr, vq[i].strb, vq[i].wdata, vq[i].prot, rdata, err, lat, wbad);
      check({vq[i].name, "_prdata"}, rdata, vq[i].exp_rdata);
      check({vq[i].name, "_pslverr"}, {31'h0, err}, {31'h0, vq[i].exp_err});
      check({vq[i].name, "_latency"}, lat, LAT);
      check({vq[i].name, "_waitquiet"}, {31'h0, wbad}, 32'h0);
    end
    go_idle();

    // Abort: psel dropped in the first ACCESS cycle, write must not land.
    @(posedge pclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h1018; bus.pwrite = 1'b1;
    bus.pstrb = 4'hF; bus.pwdata = 32'h1234_ABCD; bus.pprot = 3'b000;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    @(posedge pclk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    repeat (6) @(posedge pclk);
    apb_xfer(32'h1018, 1'b0, 4'hF, 32'h0, 3'b000, rdata, err, lat, wbad);
    check("abort_rd_prdata", rdata, 32'h0);
    check("abort_rd_latency", lat, LAT);
    go_idle();

    // Reset while pready is high but before the completing edge.
    @(posedge pclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 32'h1010; bus.pwrite = 1'b1;
    bus.pstrb = 4'hF; bus.pwdata = 32'hFFFF_FFFF; bus.pprot = 3'b000;
    repeat (LAT) begin
      @(posedge pclk); #1;
      bus.penable = 1'b1;
    end
    @(negedge pclk);
    check("midrst_pre_pready", {31'h0, bus.pready}, 32'h1);
    #1 preset_n = 1'b0;
    #1;
    check("midrst_pready", {31'h0, bus.pready}, 32'h0);
    check("midrst_pslverr", {31'h0, bus.pslverr}, 32'h0);
    check("midrst_prdata", bus.prdata, 32'h0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    go_idle();
    apb_xfer(32'h1010, 1'b0, 4'hF, 32'h0, 3'b000, rdata, err, lat, wbad);
    check("midrst_rd_1010", rdata, 32'h0);
    go_idle();
    apb_xfer(32'h1004, 1'b0, 4'hF, 32'h0, 3'b000, rdata, err, lat, wbad);
    check("midrst_mem_cleared", rdata, 32'h0);
    go_idle();
    repeat (2) @(posedge pclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
